// File: rtl/isa_pkg.sv
// Shared ISA constants for the fetch stage: opcode field layout, opcode
// encodings and the bubble instruction.
package isa_pkg;
  localparam int OPCODE_W  = 5;
  localparam int OPERAND_W = 4;
  localparam int ISA_W     = OPCODE_W + OPERAND_W;

  localparam logic [OPCODE_W-1:0] OP_ADD   = 5'h01;
  localparam logic [OPCODE_W-1:0] OP_SUB   = 5'h02;
  localparam logic [OPCODE_W-1:0] OP_SETI  = 5'h0C;
  localparam logic [OPCODE_W-1:0] OP_HALT  = 5'h1A;
  localparam logic [OPCODE_W-1:0] OP_RSCNT = 5'h1C;

  localparam logic [ISA_W-1:0] NOP_INST = '0;
endpackage

// File: rtl/inst_mem_array.sv
// Single-port DEPTH x INST_W instruction store: synchronous write,
// synchronous read. The read register holds its value when re_i is low,
// which lets the fetch stage freeze its output during a stall.
module inst_mem_array #(
  parameter int              INST_W   = 9,
  parameter int              DEPTH    = 128,
  parameter int              IDX_W    = 7,
  parameter logic [INST_W-1:0] INIT_WORD = '0
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [INST_W-1:0] wdata_i,
  output logic [INST_W-1:0] rdata_o
);
  // Power-up contents: every word reads as the bubble until written.
  logic [INST_W-1:0] mem_q [DEPTH] = '{default: INIT_WORD};
  logic [INST_W-1:0] rdata_q = INIT_WORD;

  // One shared address port: either write or read on a given edge.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/instruction_mem.sv
// Instruction fetch memory: one-cycle registered fetch with program load,
// stall, flush, sticky halt detection and sticky out-of-range PC flag.
module instruction_mem
  import isa_pkg::*;
#(
  parameter int                INST_W   = 9,
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 128,
  parameter logic [INST_W-1:0] NOP_INST = isa_pkg::NOP_INST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              stall,
  input  logic              flush,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [INST_W-1:0] load_data,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted,
  output logic              pc_oob
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic              valid_q, valid_d;
  logic              sel_q, sel_d;      // 1: inst comes from the array read register
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic              halted_q, halted_d;
  logic              oob_q, oob_d;

  logic              mem_we, mem_re;
  logic [IDX_W-1:0]  mem_addr;
  logic [INST_W-1:0] mem_rdata;
  logic              pc_in_rng, ld_in_rng;

  assign pc_in_rng = (64'(pc) < 64'(DEPTH));
  assign ld_in_rng = (64'(load_addr) < 64'(DEPTH));

  inst_mem_array #(
    .INST_W   (INST_W),
    .DEPTH    (DEPTH),
    .IDX_W    (IDX_W),
    .INIT_WORD(NOP_INST)
  ) u_array (
    .clk    (clk),
    .we_i   (mem_we),
    .re_i   (mem_re),
    .addr_i (mem_addr),
    .wdata_i(load_data),
    .rdata_o(mem_rdata)
  );

  // Per-edge priority: load > flush > stall > fetch (reset applied in the flop).
  always_comb begin
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    mem_addr = pc[IDX_W-1:0];
    valid_d  = valid_q;
    sel_d    = sel_q;
    pc_out_d = pc_out_q;
    oob_d    = oob_q;
    // Halt latches one edge after a real fetch of the halt opcode is presented.
    halted_d = halted_q | (valid_q && inst[INST_W-1 -: OPCODE_W] == OP_HALT);
    if (load_en) begin
      mem_we   = ld_in_rng && !rst;
      mem_addr = load_addr[IDX_W-1:0];
      valid_d  = 1'b0;
      sel_d    = 1'b0;
    end else if (flush) begin
      valid_d  = 1'b0;
      sel_d    = 1'b0;
      pc_out_d = pc;
    end else if (!stall) begin
      mem_re   = pc_in_rng && !rst;
      valid_d  = 1'b1;
      sel_d    = pc_in_rng;
      pc_out_d = pc;
      oob_d    = oob_q | !pc_in_rng;
    end
  end

  // Fetch-stage control and sticky status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      sel_q    <= 1'b0;
      pc_out_q <= '0;
      halted_q <= 1'b0;
      oob_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      sel_q    <= sel_d;
      pc_out_q <= pc_out_d;
      halted_q <= halted_d;
      oob_q    <= oob_d;
    end
  end

  assign inst       = sel_q ? mem_rdata : NOP_INST;
  assign inst_valid = valid_q;
  assign pc_out     = pc_out_q;
  assign halted     = halted_q;
  assign pc_oob     = oob_q;
endmodule

// File: tb/tb_instruction_mem.sv
// Directed bench for instruction_mem: load/fetch, stall, flush, halt,
// out-of-range PC and reset behaviour.
module tb_instruction_mem;
  logic        clk = 1'b0;
  logic        rst, stall, flush, load_en;
  logic [15:0] pc, load_addr;
  logic [8:0]  load_data;
  logic [8:0]  inst;
  logic        inst_valid, halted, pc_oob;
  logic [15:0] pc_out;
  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  instruction_mem dut (
    .clk(clk), .rst(rst), .pc(pc), .stall(stall), .flush(flush),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .inst(inst), .inst_valid(inst_valid), .pc_out(pc_out),
    .halted(halted), .pc_oob(pc_oob)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    rst = 0; stall = 0; flush = 0; load_en = 0; load_addr = 0; load_data = 0;
  endtask

  task automatic load(input logic [15:0] a, input logic [8:0] d);
    idle(); load_en = 1; load_addr = a; load_data = d; tick(); load_en = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1; pc = 16'd9; tick(); tick();
    total_cnt++; if (inst !== 9'h000) $display("FAIL rst_inst got %h exp 000", inst); else pass_cnt++;
    total_cnt++; if (inst_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", inst_valid); else pass_cnt++;
    total_cnt++; if (pc_out !== 16'd0) $display("FAIL rst_pc_out got %0d exp 0", pc_out); else pass_cnt++;
    total_cnt++; if (halted !== 1'b0 || pc_oob !== 1'b0) $display("FAIL rst_sticky got %b%b exp 00", halted, pc_oob); else pass_cnt++;
    // first edge after reset is a real fetch of an unwritten word
    rst = 0; pc = 16'd10; tick();
    total_cnt++; if (inst !== 9'h000 || inst_valid !== 1'b1 || pc_out !== 16'd10)
      $display("FAIL post_rst_fetch got %h/%b/%0d exp 000/1/10", inst, inst_valid, pc_out); else pass_cnt++;
  endtask

  task automatic test_load_fetch();
    load(16'd1, 9'h1C0);
    total_cnt++; if (inst !== 9'h000 || inst_valid !== 1'b0)
      $display("FAIL load_bubble got %h/%b exp 000/0", inst, inst_valid); else pass_cnt++;
    load(16'd2, 9'h0C0);
    pc = 16'd1; tick();
    total_cnt++; if (inst !== 9'h1C0 || inst_valid !== 1'b1 || pc_out !== 16'd1)
      $display("FAIL fetch_pc1 got %h/%b/%0d exp 1C0/1/1", inst, inst_valid, pc_out); else pass_cnt++;
    pc = 16'd2; tick();
    total_cnt++; if (inst !== 9'h0C0 || inst_valid !== 1'b1 || pc_out !== 16'd2)
      $display("FAIL fetch_pc2 got %h/%b/%0d exp 0C0/1/2", inst, inst_valid, pc_out); else pass_cnt++;
    total_cnt++; if (halted !== 1'b0) $display("FAIL no_halt got %b exp 0", halted); else pass_cnt++;
  endtask

  task automatic test_stall();
    load(16'd3, 9'h011);
    load(16'd6, 9'h066);
    pc = 16'd3; tick();
    stall = 1;
    for (int p = 4; p <= 6; p++) begin
      pc = 16'(p); tick();
      total_cnt++; if (inst !== 9'h011 || pc_out !== 16'd3 || inst_valid !== 1'b1)
        $display("FAIL stall_hold_%0d got %h/%0d/%b exp 011/3/1", p, inst, pc_out, inst_valid); else pass_cnt++;
    end
    stall = 0; tick();
    total_cnt++; if (inst !== 9'h066 || pc_out !== 16'd6)
      $display("FAIL stall_release got %h/%0d exp 066/6", inst, pc_out); else pass_cnt++;
  endtask

  task automatic test_flush();
    pc = 16'd4; flush = 1; stall = 1; tick();
    total_cnt++; if (inst !== 9'h000 || inst_valid !== 1'b0 || pc_out !== 16'd4)
      $display("FAIL flush_over_stall got %h/%b/%0d exp 000/0/4", inst, inst_valid, pc_out); else pass_cnt++;
    flush = 0; stall = 0;
  endtask

  task automatic test_write_fetch();
    load(16'd7, 9'h0AB);
    pc = 16'd7; tick();
    total_cnt++; if (inst !== 9'h0AB) $display("FAIL wr_then_rd got %h exp 0AB", inst); else pass_cnt++;
    rst = 1; load_en = 1; load_addr = 16'd7; load_data = 9'h155; tick();
    idle(); pc = 16'd7; tick();
    total_cnt++; if (inst !== 9'h0AB || inst_valid !== 1'b1)
      $display("FAIL load_in_rst got %h/%b exp 0AB/1", inst, inst_valid); else pass_cnt++;
  endtask

  task automatic test_halt();
    load(16'd5, 9'h1A0);
    pc = 16'd5; flush = 1; tick();
    flush = 0; pc = 16'd0; tick(); tick();
    total_cnt++; if (halted !== 1'b0) $display("FAIL halt_flushed got %b exp 0", halted); else pass_cnt++;
    pc = 16'd5; tick();
    total_cnt++; if (inst !== 9'h1A0 || halted !== 1'b0)
      $display("FAIL halt_fetch got %h/%b exp 1A0/0", inst, halted); else pass_cnt++;
    pc = 16'd0; tick();
    total_cnt++; if (halted !== 1'b1) $display("FAIL halt_set got %b exp 1", halted); else pass_cnt++;
    tick();
    total_cnt++; if (halted !== 1'b1) $display("FAIL halt_sticky got %b exp 1", halted); else pass_cnt++;
    rst = 1; tick(); rst = 0;
    total_cnt++; if (halted !== 1'b0) $display("FAIL halt_rst got %b exp 0", halted); else pass_cnt++;
  endtask

  task automatic test_oob();
    pc = 16'd200; tick();
    total_cnt++; if (inst !== 9'h000 || inst_valid !== 1'b1 || pc_out !== 16'd200 || pc_oob !== 1'b1)
      $display("FAIL oob_fetch got %h/%b/%0d/%b exp 000/1/200/1", inst, inst_valid, pc_out, pc_oob); else pass_cnt++;
    pc = 16'd1; tick();
    total_cnt++; if (inst !== 9'h1C0 || pc_oob !== 1'b1)
      $display("FAIL oob_sticky got %h/%b exp 1C0/1", inst, pc_oob); else pass_cnt++;
    load(16'd200, 9'h1FF);
    pc = 16'd72; tick();
    total_cnt++; if (inst !== 9'h000) $display("FAIL oob_wr_alias got %h exp 000", inst); else pass_cnt++;
    pc = 16'd1; tick();
    total_cnt++; if (inst !== 9'h1C0) $display("FAIL oob_wr_keep got %h exp 1C0", inst); else pass_cnt++;
  endtask

  initial begin
    idle(); pc = 0;
    test_reset();
    test_load_fetch();
    test_stall();
    test_flush();
    test_write_fetch();
    test_halt();
    test_oob();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/instruction_mem.md
INSTRUCTION_MEM -- requirements
Module: instruction_mem

Interface
REQ-001 SHALL have parameter INST_W, default 9, meaning instruction width (5-bit opcode + operand).
REQ-002 SHALL have parameter ADDR_W, default 16, meaning PC width.
REQ-003 SHALL have parameter DEPTH, default 128, meaning number of instruction words.
REQ-004 SHALL have parameter NOP_INST, default 0, meaning the bubble instruction.
REQ-005 SHALL have port clk  input  1  system clock; one clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port pc  input  ADDR_W  fetch address.
REQ-008 SHALL have port stall  input  1  hold fetch outputs.
REQ-009 SHALL have port flush  input  1  replace the next output with a bubble.
REQ-010 SHALL have port load_en  input  1  program-load write strobe.
REQ-011 SHALL have port load_addr  input  ADDR_W  program-load address.
REQ-012 SHALL have port load_data  input  INST_W  program-load word.
REQ-013 SHALL have port inst  output  INST_W  fetched instruction, registered.
REQ-014 SHALL have port inst_valid  output  1  inst is a real fetch.
REQ-015 SHALL have port pc_out  output  ADDR_W  PC that produced inst.
REQ-016 SHALL have port halted  output  1  sticky; a valid halt opcode has been fetched.
REQ-017 SHALL have port pc_oob  output  1  sticky; a fetch with pc >= DEPTH occurred.

Function
REQ-018 SHALL have a read latency of 1: pc sampled at edge N gives inst/pc_out/inst_valid after edge N.
REQ-019 SHALL apply per-edge priority rst > load_en > flush > stall > normal fetch.
REQ-020 SHALL on load_en write load_data to word load_addr when load_addr < DEPTH, silently drop out-of-range writes, and set inst=NOP_INST, inst_valid=0 that cycle.
REQ-021 SHALL return the new word when a fetch of the same address follows a write one cycle later; no stale data.
REQ-022 SHALL on flush (load_en low) set inst=NOP_INST, inst_valid=0, pc_out=pc; flush overrides stall.
REQ-023 SHALL on stall (load_en, flush low) hold inst, inst_valid and pc_out unchanged and take no new fetch.
REQ-024 SHALL on a normal fetch with pc < DEPTH set inst=mem[pc], inst_valid=1, pc_out=pc.
REQ-025 SHALL on a normal fetch with pc >= DEPTH set inst=NOP_INST, inst_valid=1, pc_out=pc, and set pc_oob.
REQ-026 SHALL set halted on the edge after a normal fetch whose opcode (inst[INST_W-1:INST_W-5]) equals OP_HALT (5'b11010), and hold it until reset.
REQ-027 SHALL NOT let a halt word that is loaded but never fetched, or that is flushed, set halted.
REQ-028 SHALL leave memory words never written reading as NOP_INST after power-up initialisation.

Reset
REQ-029 SHALL on rst set inst=NOP_INST, inst_valid=0, pc_out=0, halted=0, pc_oob=0.
REQ-030 SHALL ignore load_en in a reset cycle and SHALL NOT clear memory contents on reset.
REQ-031 SHALL resume normal fetch on the first edge after rst deasserts, with no extra bubble.

Structure
REQ-032 SHALL take opcode constants (add..halt), OPCODE_W=5, OPERAND_W and NOP_INST from shared package isa_pkg.
REQ-033 SHALL instantiate exactly one sub-module, inst_mem_array: a single-port, synchronous-write, synchronous-read DEPTH x INST_W array.

Verification
REQ-034 SHALL be verified by: load mem[1]=9'h1C0 (rsCnt), mem[2]=9'h0C0 (seti 0); pc=1,2 -> inst 9'h1C0 then 9'h0C0, valid=1, each one cycle after its pc.
REQ-035 SHALL be verified by: stall held 3 cycles while pc moves 3->6 -> inst/pc_out stay at pc=3 values; after release, the pc=6 word appears next cycle.
REQ-036 SHALL be verified by: flush and stall high together at pc=4 -> inst=0, inst_valid=0, pc_out=4.
REQ-037 SHALL be verified by: mem[5]=9'h1A0 (halt) fetched -> halted=1 next cycle; the same fetch with flush -> halted stays 0; rst -> halted=0.
REQ-038 SHALL be verified by: pc=200 with DEPTH=128 -> inst=0, inst_valid=1, pc_oob=1 sticky; load to address 200 does not alter any word.
REQ-039 SHALL be verified by: write mem[7]=9'h0AB, then fetch pc=7 on the next cycle -> inst=9'h0AB; load_en during rst -> mem[7] is unchanged.
